// File: rtl/ahb_resp_mux_s4_if.sv
// Slave-to-master response path bundle for the four-slave AHB interconnect.
// The "slave" modport is the mux's view; "master" is the driving/observing side.
interface ahb_resp_mux_s4_if;
  logic        SEL0;
  logic        SEL1;
  logic        SEL2;
  logic        SEL3;
  logic [1:0]  HTRANSm;
  logic [31:0] HRDATAS0;
  logic [31:0] HRDATAS1;
  logic [31:0] HRDATAS2;
  logic [31:0] HRDATAS3;
  logic        HREADYOUTS0;
  logic        HREADYOUTS1;
  logic        HREADYOUTS2;
  logic        HREADYOUTS3;
  logic [1:0]  HRESPS0;
  logic [1:0]  HRESPS1;
  logic [1:0]  HRESPS2;
  logic [1:0]  HRESPS3;
  logic [31:0] HRDATAm;
  logic        HREADYm;
  logic [1:0]  HRESPm;
  logic        DEFERRm;

  modport slave (
    input  SEL0, SEL1, SEL2, SEL3, HTRANSm,
    input  HRDATAS0, HRDATAS1, HRDATAS2, HRDATAS3,
    input  HREADYOUTS0, HREADYOUTS1, HREADYOUTS2, HREADYOUTS3,
    input  HRESPS0, HRESPS1, HRESPS2, HRESPS3,
    output HRDATAm, HREADYm, HRESPm, DEFERRm
  );

  modport master (
    output SEL0, SEL1, SEL2, SEL3, HTRANSm,
    output HRDATAS0, HRDATAS1, HRDATAS2, HRDATAS3,
    output HREADYOUTS0, HREADYOUTS1, HREADYOUTS2, HREADYOUTS3,
    output HRESPS0, HRESPS1, HRESPS2, HRESPS3,
    input  HRDATAm, HREADYm, HRESPm, DEFERRm
  );
endinterface

// File: rtl/ahb_resp_mux_s4.sv
// AHB slave-to-master response mux: latches the address-phase select into a
// data-phase owner and routes that slave back; a built-in default slave ERRORs.
module ahb_resp_mux_s4 (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_resp_mux_s4_if.slave     bus,
  output logic [2:0]           dbg_dstate
);

  typedef enum logic [2:0] {
    D_NONE = 3'd0,
    D_S0   = 3'd1,
    D_S1   = 3'd2,
    D_S2   = 3'd3,
    D_S3   = 3'd4,
    D_ERR1 = 3'd5,
    D_ERR2 = 3'd6
  } dstate_e;

  dstate_e     dstate_q;
  dstate_e     dstate_d;
  dstate_e     sampled;
  logic [3:0]  sel;
  logic [31:0] rdata_r;
  logic        ready_r;
  logic [1:0]  resp_r;
  logic        deferr_r;

  assign sel        = {bus.SEL3, bus.SEL2, bus.SEL1, bus.SEL0};
  assign dbg_dstate = dstate_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dstate_q <= D_NONE;
    end else begin
      dstate_q <= dstate_d;
    end
  end

  // Routing from the current data-phase owner, before the reset override.
  always_comb begin
    rdata_r  = 32'h0;
    ready_r  = 1'b1;
    resp_r   = 2'b00;
    deferr_r = 1'b0;
    case (dstate_q)
      D_S0: begin
        rdata_r = bus.HRDATAS0;
        ready_r = bus.HREADYOUTS0;
        resp_r  = bus.HRESPS0;
      end
      D_S1: begin
        rdata_r = bus.HRDATAS1;
        ready_r = bus.HREADYOUTS1;
        resp_r  = bus.HRESPS1;
      end
      D_S2: begin
        rdata_r = bus.HRDATAS2;
        ready_r = bus.HREADYOUTS2;
        resp_r  = bus.HRESPS2;
      end
      D_S3: begin
        rdata_r = bus.HRDATAS3;
        ready_r = bus.HREADYOUTS3;
        resp_r  = bus.HRESPS3;
      end
      D_ERR1: begin
        ready_r = 1'b0;
        resp_r  = 2'b01;
      end
      D_ERR2: begin
        resp_r   = 2'b01;
        deferr_r = 1'b1;
      end
      default: ;
    endcase
  end

  // Address-phase decode: a non-one-hot select is only an error when the
  // master is actually transferring (NONSEQ/SEQ).
  always_comb begin
    sampled = D_NONE;
    case (sel)
      4'b0001: sampled = D_S0;
      4'b0010: sampled = D_S1;
      4'b0100: sampled = D_S2;
      4'b1000: sampled = D_S3;
      default: sampled = bus.HTRANSm[1] ? D_ERR1 : D_NONE;
    endcase
  end

  always_comb begin
    dstate_d = dstate_q;
    if (dstate_q == D_ERR1) begin
      dstate_d = D_ERR2;
    end else if (ready_r) begin
      dstate_d = sampled;
    end
  end

  always_comb begin
    bus.HRDATAm = rdata_r;
    bus.HREADYm = ready_r;
    bus.HRESPm  = resp_r;
    bus.DEFERRm = deferr_r;
    if (!HRESETn) begin
      bus.HRDATAm = 32'h0;
      bus.HREADYm = 1'b1;
      bus.HRESPm  = 2'b00;
      bus.DEFERRm = 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux_s4.sv
// Bench for ahb_resp_mux_s4: directed scenarios with literal expectations plus
// a randomized run against a transfer-level reference model.
module tb_ahb_resp_mux_s4;

  logic        HCLK;
  logic        HRESETn;
  logic [2:0]  dbg_dstate;
  logic [3:0]  sel_v;
  logic [1:0]  htrans_v;
  logic [31:0] sd [4];
  logic        sr [4];
  logic [1:0]  sp [4];

  int n_vec;
  int n_bad;
  // Model: owner -1 none, 0..3 slave, 4 = first default-ERROR cycle, 5 = second.
  int owner;
  logic [35:0] exp_q[$];

  ahb_resp_mux_s4_if bus ();

  assign bus.SEL0        = sel_v[0];
  assign bus.SEL1        = sel_v[1];
  assign bus.SEL2        = sel_v[2];
  assign bus.SEL3        = sel_v[3];
  assign bus.HTRANSm     = htrans_v;
  assign bus.HRDATAS0    = sd[0];
  assign bus.HRDATAS1    = sd[1];
  assign bus.HRDATAS2    = sd[2];
  assign bus.HRDATAS3    = sd[3];
  assign bus.HREADYOUTS0 = sr[0];
  assign bus.HREADYOUTS1 = sr[1];
  assign bus.HREADYOUTS2 = sr[2];
  assign bus.HREADYOUTS3 = sr[3];
  assign bus.HRESPS0     = sp[0];
  assign bus.HRESPS1     = sp[1];
  assign bus.HRESPS2     = sp[2];
  assign bus.HRESPS3     = sp[3];

  ahb_resp_mux_s4 dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .bus        (bus.slave),
    .dbg_dstate (dbg_dstate)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1);
  end

  function automatic logic [35:0] obs();
    return {bus.HRDATAm, bus.HREADYm, bus.HRESPm, bus.DEFERRm};
  endfunction

  // Expected {HRDATAm, HREADYm, HRESPm, DEFERRm} for the current cycle.
  function automatic logic [35:0] model_out();
    if (!HRESETn) return {32'h0, 1'b1, 2'b00, 1'b0};
    if (owner >= 0 && owner <= 3) return {sd[owner], sr[owner], sp[owner], 1'b0};
    if (owner == 4) return {32'h0, 1'b0, 2'b01, 1'b0};
    if (owner == 5) return {32'h0, 1'b1, 2'b01, 1'b1};
    return {32'h0, 1'b1, 2'b00, 1'b0};
  endfunction

  // Advance one clock, updating the model from what the edge will sample.
  task automatic tick();
    logic [35:0] e;
    int nxt;
    e   = model_out();
    nxt = owner;
    if (!HRESETn) nxt = -1;
    else if (owner == 4) nxt = 5;
    else if (e[3]) begin
      if ($countones(sel_v) == 1) begin
        for (int i = 0; i < 4; i++) if (sel_v[i]) nxt = i;
      end else begin
        nxt = htrans_v[1] ? 4 : -1;
      end
    end
    @(posedge HCLK);
    owner = nxt;
    #1;
  endtask

  task automatic set_addr(input logic [3:0] s, input logic [1:0] t);
    sel_v    = s;
    htrans_v = t;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    set_addr(4'b0010, 2'b10);
    sr[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      n_vec++;
      if (obs() !== {32'h0, 1'b1, 2'b00, 1'b0}) begin
        $display("FAIL reset_hold[%0d]: got %h want %h", i, obs(), {32'h0, 1'b1, 2'b00, 1'b0});
        n_bad++;
      end
      tick();
    end
    HRESETn = 1'b1;
    sr[1] = 1'b1;
    set_addr(4'b0000, 2'b00);
    @(negedge HCLK);
    n_vec++;
    if (obs() !== {32'h0, 1'b1, 2'b00, 1'b0}) begin
      $display("FAIL reset_release: got %h want %h", obs(), {32'h0, 1'b1, 2'b00, 1'b0});
      n_bad++;
    end
    tick();
  endtask

  task automatic test_single_read();
    set_addr(4'b0100, 2'b10);
    tick();
    set_addr(4'b0000, 2'b00);
    sd[0] = 32'h1111_0000;
    sd[1] = 32'h2222_0001;
    sd[3] = 32'h4444_0003;
    sd[2] = 32'hA5A5_0002;
    sr[2] = 1'b1;
    @(negedge HCLK);
    n_vec++;
    if (obs() !== {32'hA5A5_0002, 1'b1, 2'b00, 1'b0}) begin
      $display("FAIL single_read_s2: got %h want %h", obs(), {32'hA5A5_0002, 1'b1, 2'b00, 1'b0});
      n_bad++;
    end
    tick();
  endtask

  task automatic test_wait_b2b();
    set_addr(4'b0001, 2'b10);
    tick();
    set_addr(4'b1000, 2'b10);
    sd[0] = 32'h0BAD_0000;
    sr[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      n_vec++;
      if (obs() !== {32'h0BAD_0000, 1'b0, 2'b00, 1'b0}) begin
        $display("FAIL wait_s0[%0d]: got %h want %h", i, obs(), {32'h0BAD_0000, 1'b0, 2'b00, 1'b0});
        n_bad++;
      end
      tick();
    end
    sr[0] = 1'b1;
    sd[0] = 32'hC0DE_0000;
    @(negedge HCLK);
    n_vec++;
    if (obs() !== {32'hC0DE_0000, 1'b1, 2'b00, 1'b0}) begin
      $display("FAIL wait_s0_done: got %h want %h", obs(), {32'hC0DE_0000, 1'b1, 2'b00, 1'b0});
      n_bad++;
    end
    tick();
    set_addr(4'b0000, 2'b00);
    sd[3] = 32'h1234_5678;
    @(negedge HCLK);
    n_vec++;
    if (obs() !== {32'h1234_5678, 1'b1, 2'b00, 1'b0}) begin
      $display("FAIL b2b_s3: got %h want %h", obs(), {32'h1234_5678, 1'b1, 2'b00, 1'b0});
      n_bad++;
    end
    tick();
  endtask

  // Shared by the unmapped and multi-select cases: the default-slave sequence.
  task automatic test_default_err(input logic [3:0] s, input logic [1:0] t, input string nm);
    set_addr(s, t);
    tick();
    set_addr(4'b0000, 2'b00);
    @(negedge HCLK);
    n_vec++;
    if (obs() !== {32'h0, 1'b0, 2'b01, 1'b0}) begin
      $display("FAIL %s_err1: got %h want %h", nm, obs(), {32'h0, 1'b0, 2'b01, 1'b0});
      n_bad++;
    end
    tick();
    @(negedge HCLK);
    n_vec++;
    if (obs() !== {32'h0, 1'b1, 2'b01, 1'b1}) begin
      $display("FAIL %s_err2: got %h want %h", nm, obs(), {32'h0, 1'b1, 2'b01, 1'b1});
      n_bad++;
    end
    tick();
    @(negedge HCLK);
    n_vec++;
    if (obs() !== {32'h0, 1'b1, 2'b00, 1'b0}) begin
      $display("FAIL %s_after: got %h want %h", nm, obs(), {32'h0, 1'b1, 2'b00, 1'b0});
      n_bad++;
    end
    tick();
  endtask

  task automatic test_idle_no_sel();
    for (int i = 0; i < 2; i++) begin
      set_addr(4'b0000, 2'b00);
      tick();
      @(negedge HCLK);
      n_vec++;
      if (obs() !== {32'h0, 1'b1, 2'b00, 1'b0}) begin
        $display("FAIL idle_okay[%0d]: got %h want %h", i, obs(), {32'h0, 1'b1, 2'b00, 1'b0});
        n_bad++;
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_err();
    set_addr(4'b0000, 2'b10);
    tick();
    set_addr(4'b0000, 2'b00);
    @(negedge HCLK);
    n_vec++;
    if (obs() !== {32'h0, 1'b0, 2'b01, 1'b0}) begin
      $display("FAIL rst_err_enter: got %h want %h", obs(), {32'h0, 1'b0, 2'b01, 1'b0});
      n_bad++;
    end
    HRESETn = 1'b0;
    #1;
    n_vec++;
    if (obs() !== {32'h0, 1'b1, 2'b00, 1'b0}) begin
      $display("FAIL rst_err_forced: got %h want %h", obs(), {32'h0, 1'b1, 2'b00, 1'b0});
      n_bad++;
    end
    tick();
    HRESETn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      n_vec++;
      if (obs() !== {32'h0, 1'b1, 2'b00, 1'b0}) begin
        $display("FAIL rst_err_after[%0d]: got %h want %h", i, obs(), {32'h0, 1'b1, 2'b00, 1'b0});
        n_bad++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [35:0] e;
    for (int c = 0; c < 400; c++) begin
      HRESETn = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 9) < 6) sel_v = 4'b0001 << $urandom_range(0, 3);
      else sel_v = 4'($urandom_range(0, 15));
      htrans_v = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) begin
        sd[i] = $urandom;
        sr[i] = ($urandom_range(0, 9) < 7);
        sp[i] = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
      end
      exp_q.push_back(model_out());
      @(negedge HCLK);
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        $display("FAIL random[%0d]: got %h want %h", c, obs(), e);
        n_bad++;
      end
      tick();
    end
    HRESETn = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    owner = -1;
    HRESETn = 1'b0;
    sel_v = 4'b0000;
    htrans_v = 2'b00;
    for (int i = 0; i < 4; i++) begin
      sd[i] = 32'hDEAD_0000 | 32'(i);
      sr[i] = 1'b1;
      sp[i] = 2'b00;
    end
    #1;
    test_reset();
    test_single_read();
    test_wait_b2b();
    test_default_err(4'b0000, 2'b10, "unmapped");
    test_default_err(4'b0011, 2'b11, "multisel");
    test_idle_no_sel();
    test_reset_mid_err();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_resp_mux_s4.md
# ahb_resp_mux_s4

Slave-to-master response multiplexer for the four-slave AHB interconnect. It completes the path back from the slaves to the master, opposite to the master-to-slave address/write-data mux. It latches the address-phase slave select into a data-phase select register and routes the selected slave's HRDATA/HREADYOUT/HRESP to the master. It also contains a built-in default slave that returns a two-cycle ERROR response for active transfers that hit no slave, or more than one slave.

## Interface
- No parameters. Data width is fixed at 32 and the slave count is fixed at 4.
- HCLK  input  1  clock; all state updates on the rising edge.
- HRESETn  input  1  synchronous reset, active-low. One clock; reset is synchronous and active-low.
- SEL0, SEL1, SEL2, SEL3  input  1 each  address-phase slave selects from the decoder; valid one-hot when SEL0..SEL3 contain exactly one 1.
- HTRANSm  input  2  master address-phase HTRANS: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HRDATAS0..HRDATAS3  input  32 each  slave read data.
- HREADYOUTS0..HREADYOUTS3  input  1 each  slave ready.
- HRESPS0..HRESPS3  input  2 each  slave response: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
- HRDATAm  output  32  read data to master.
- HREADYm  output  1  HREADY to master; also fed back to the slaves as HREADYIN.
- HRESPm  output  2  response to master.
- DEFERRm  output  1  one-cycle pulse when the default slave completes an ERROR response.

## Operation
- Data-phase state dstate takes one of these values:
  - NONE — no slave owns the data phase.
  - S0, S1, S2, S3 — slave n owns the data phase.
  - ERR1 — default slave, first ERROR cycle.
  - ERR2 — default slave, second ERROR cycle.
- Address sampling: when HREADYm=1 at a rising edge, dstate loads the next value from SEL0..SEL3 and HTRANSm:
  - Exactly one SELn=1 → Sn, regardless of HTRANSm.
  - SEL not one-hot and HTRANSm[1]=1 (NONSEQ or SEQ) → ERR1.
  - SEL not one-hot and HTRANSm[1]=0 (IDLE or BUSY) → NONE.
- When HREADYm=0, dstate holds, except in ERR1.
- ERR1 → ERR2 unconditionally on the next edge. HTRANSm and SEL are ignored during ERR1, including a master switching to IDLE.
- ERR2 has HREADYm=1, so the next address phase is sampled normally at the edge leaving ERR2.
- Output routing is combinational from dstate:
  - Sn: HRDATAm=HRDATASn, HREADYm=HREADYOUTSn, HRESPm=HRESPSn. RETRY and SPLIT pass through unchanged.
  - NONE: HRDATAm=0, HREADYm=1, HRESPm=00.
  - ERR1: HRDATAm=0, HREADYm=0, HRESPm=01.
  - ERR2: HRDATAm=0, HREADYm=1, HRESPm=01.
- DEFERRm=1 exactly in ERR2, otherwise 0.
- Reset:
  - While HRESETn=0, outputs are forced combinationally to HRDATAm=0, HREADYm=1, HRESPm=00, DEFERRm=0.
  - At the rising edge with HRESETn=0, dstate=NONE.
  - Reset asserted mid-operation (in Sn with HREADYOUTSn=0, or in ERR1/ERR2) abandons the transfer. After release the block is in NONE; no ERR2 and no DEFERRm pulse follow.

## Timing
- Select latency: SEL and HTRANSm sampled at edge k drive the routing from edge k to edge k+1 onward (standard AHB address→data pipeline).
- Routing latency: HRDATA, HREADY and HRESP from the selected slave reach the master with zero cycles of latency, in the same cycle.
- Wait states: a data phase extends for as long as the selected slave holds HREADYOUT=0. dstate does not change during wait states, even if SEL changes.
- Back-to-back transfers to different slaves switch dstate on the edge where HREADYm=1, with no bubble cycle.
- Default-slave ERROR is always exactly 2 cycles (HREADY 0 then 1, with HRESP=01 on both), followed by normal sampling.
- A slave's own two-cycle ERROR, RETRY or SPLIT response is passed through cycle-exact; this block adds no stall.

## Test plan
- Reset check: hold HRESETn=0 for 3 cycles with SEL1=1, HTRANSm=10 and HREADYOUTS1=0 → HREADYm=1, HRESPm=00, HRDATAm=0 throughout; after release, one IDLE cycle gives HREADYm=1.
- Single read, S2:
  - Edge 0: SEL2=1, HTRANSm=10.
  - Next cycle: HRDATAS2=0xA5A5_0002, HREADYOUTS2=1.
  - Required: HRDATAm=0xA5A5_0002, HRESPm=00, HREADYm=1. The HRDATAS0/1/3 values are not visible on HRDATAm.
- Wait states plus back-to-back:
  - S0 holds HREADYOUTS0=0 for 3 cycles while SEL3=1 is presented.
  - Required: HREADYm=0 for those 3 cycles with dstate held at S0; on the cycle HREADYOUTS0=1, dstate moves to S3 at that edge.
  - Then HRDATAS3=0x1234_5678 appears on HRDATAm in the following cycle.
- Unmapped NONSEQ, all SEL=0, HTRANSm=10 → next cycle HREADYm=0/HRESPm=01; following cycle HREADYm=1/HRESPm=01/DEFERRm=1; then with HTRANSm=00, HREADYm=1/HRESPm=00.
- Multi-select and idle cases:
  - SEL0=SEL1=1 with HTRANSm=11 → same two-cycle ERROR sequence.
  - All SEL=0 with HTRANSm=00 → zero-wait OKAY and DEFERRm stays 0.
- Reset mid-ERROR: assert HRESETn=0 during ERR1 for 1 cycle → no DEFERRm pulse, then HREADYm=1 and HRESPm=00.
